// File: rtl/board_reset_sequencer.sv
// board_reset_sequencer: debounced, lock-qualified, staggered release of active-low board resets
// i_clk             sequencer clock
// i_rst_n           synchronous active-low module reset
// i_pb              raw push-button (asynchronous)
// i_pll_locked      clock-manager lock (asynchronous)
// o_rst_n           per-channel active-low resets, released 0..NUM_CHANNELS-1
// o_all_released    high in RUN
// o_state           current state (HOLD=0 WAIT_LOCK=1 STABLE=2 RELEASE=3 RUN=4)
// o_lock_loss_count saturating count of lock losses during RELEASE/RUN
module board_reset_sequencer #(
  parameter int NUM_CHANNELS = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int STAGGER_CYCLES = 8,
  parameter bit PB_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_pb,
  input  logic                    i_pll_locked,
  output logic [NUM_CHANNELS-1:0] o_rst_n,
  output logic                    o_all_released,
  output logic [2:0]              o_state,
  output logic [7:0]              o_lock_loss_count
);
  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);
  localparam logic PB_PRESSED_RAW = ~PB_ACTIVE_LOW;
  state_t state, state_next;
  logic pb_meta, pb_sync, lock_meta, lock_sync;
  logic pb_pressed_sync, db_pressed, lock_loss;
  logic [DW-1:0] db_cnt;
  logic [LW-1:0] stable_cnt, stable_next;
  logic [SW-1:0] stag_cnt, stag_next;
  logic [NUM_CHANNELS-1:0] rst_next, rst_shifted;
  logic [7:0] count_next;
  assign pb_pressed_sync = pb_sync ^ PB_ACTIVE_LOW;
  assign lock_loss = (state == RELEASE || state == RUN) && !lock_sync;
  // next channel released: thermometer grows from bit 0 upward
  assign rst_shifted = (o_rst_n << 1) | NUM_CHANNELS'(1);
  assign o_state = state;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pb_meta <= PB_PRESSED_RAW;
      pb_sync <= PB_PRESSED_RAW;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      db_pressed <= 1'b1;
      db_cnt <= '0;
    end else begin
      pb_meta <= i_pb;
      pb_sync <= pb_meta;
      lock_meta <= i_pll_locked;
      lock_sync <= lock_meta;
      if (pb_pressed_sync == db_pressed) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_pressed <= pb_pressed_sync;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  end
  always_comb begin
    state_next = state;
    stable_next = stable_cnt;
    stag_next = stag_cnt;
    rst_next = o_rst_n;
    count_next = (lock_loss && o_lock_loss_count != 8'hff) ? o_lock_loss_count + 8'd1 : o_lock_loss_count;
    if (state != HOLD && db_pressed) begin
      state_next = HOLD;
      rst_next = '0;
    end else if (lock_loss) begin
      state_next = WAIT_LOCK;
      rst_next = '0;
    end else begin
      case (state)
        HOLD: state_next = db_pressed ? HOLD : WAIT_LOCK;
        WAIT_LOCK: begin
          state_next = lock_sync ? STABLE : WAIT_LOCK;
          stable_next = '0;
        end
        STABLE: begin
          if (!lock_sync) state_next = WAIT_LOCK;
          else if (stable_cnt == LW'(LOCK_STABLE_CYCLES - 1)) begin
            state_next = RELEASE;
            stag_next = '0;
          end else stable_next = stable_cnt + 1'b1;
        end
        RELEASE: begin
          // a channel is released whenever the stagger counter wraps through zero
          stag_next = (stag_cnt == SW'(STAGGER_CYCLES - 1)) ? '0 : stag_cnt + 1'b1;
          if (stag_cnt == '0) begin
            rst_next = rst_shifted;
            state_next = (&rst_shifted) ? RUN : RELEASE;
          end
        end
        RUN: rst_next = '1;
        default: begin
          state_next = HOLD;
          rst_next = '0;
        end
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= HOLD;
      stable_cnt <= '0;
      stag_cnt <= '0;
      o_rst_n <= '0;
      o_all_released <= 1'b0;
      o_lock_loss_count <= '0;
    end else begin
      state <= state_next;
      stable_cnt <= stable_next;
      stag_cnt <= stag_next;
      o_rst_n <= rst_next;
      o_all_released <= state_next == RUN;
      o_lock_loss_count <= count_next;
    end
  end
endmodule

// File: tb/tb_board_reset_sequencer.sv
// tb_board_reset_sequencer: directed scenarios plus random stimulus against a behavioural reference
module tb_board_reset_sequencer;
  localparam int N = 3;
  localparam int D = 4;
  localparam int L = 8;
  localparam int S = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pb = 1'b1;
  logic lk = 1'b1;
  logic [N-1:0] rst_o;
  logic all_rel;
  logic [2:0] st_o;
  logic [7:0] llc;
  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int rise[N];
  int stab_len = 0;
  int last_stab = 0;
  int t0;
  logic [2:0] prev_st = '0;
  logic [N-1:0] prev_rst = '0;
  int m_st, m_stab, m_rel, m_cnt, m_run;
  bit m_db;
  bit pb_d[2];
  bit lk_d[2];
  always #5 clk = ~clk;
  board_reset_sequencer #(
    .NUM_CHANNELS(N),
    .DEBOUNCE_CYCLES(D),
    .LOCK_STABLE_CYCLES(L),
    .STAGGER_CYCLES(S),
    .PB_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_pb(pb),
    .i_pll_locked(lk),
    .o_rst_n(rst_o),
    .o_all_released(all_rel),
    .o_state(st_o),
    .o_lock_loss_count(llc)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc_n);
    end
  endtask
  function automatic int exp_rst();
    int n;
    if (m_st == 4) return (1 << N) - 1;
    if (m_st != 3 || m_rel == 0) return 0;
    n = (m_rel - 1) / S + 1;
    if (n > N) n = N;
    return (1 << n) - 1;
  endfunction
  task automatic model_edge();
    bit ls, sp, loss;
    int nst;
    ls = lk_d[1];
    sp = !pb_d[1];
    nst = m_st;
    loss = (m_st == 3 || m_st == 4) && !ls;
    if (!rst_n) begin
      m_st = 0; m_cnt = 0; m_db = 1; m_run = 0; m_stab = 0; m_rel = 0;
      pb_d[0] = 0; pb_d[1] = 0; lk_d[0] = 0; lk_d[1] = 0;
    end else begin
      if (loss && m_cnt < 255) m_cnt++;
      if (m_st != 0 && m_db) nst = 0;
      else if (loss) nst = 1;
      else if (m_st == 0) begin
        if (!m_db) nst = 1;
      end else if (m_st == 1) begin
        if (ls) begin nst = 2; m_stab = 0; end
      end else if (m_st == 2) begin
        if (!ls) nst = 1;
        else if (m_stab == L - 1) begin nst = 3; m_rel = 0; end
        else m_stab++;
      end else if (m_st == 3) begin
        m_rel++;
        if (m_rel == (N - 1) * S + 1) nst = 4;
      end
      m_st = nst;
      if (sp != m_db) begin
        m_run++;
        if (m_run == D) begin m_db = sp; m_run = 0; end
      end else m_run = 0;
      pb_d[1] = pb_d[0]; pb_d[0] = pb;
      lk_d[1] = lk_d[0]; lk_d[0] = lk;
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    cyc_n++;
    chk("state", st_o, m_st);
    chk("rst_n", rst_o, exp_rst());
    chk("all_released", all_rel, m_st == 4);
    chk("lock_loss_count", llc, m_cnt);
    for (int k = 0; k < N; k++) if (rst_o[k] && !prev_rst[k]) rise[k] = cyc_n;
    if (st_o == 2) stab_len++;
    else begin
      if (prev_st == 2) last_stab = stab_len;
      stab_len = 0;
    end
    prev_st = st_o;
    prev_rst = rst_o;
  endtask
  task automatic wait_st(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (st_o !== s && n < budget) begin
      cyc();
      n++;
    end
    if (st_o !== s) chk(tag, st_o, s);
  endtask
  task automatic wait_rst(input logic [N-1:0] v, input int budget, input string tag);
    int n = 0;
    while (rst_o !== v && n < budget) begin
      cyc();
      n++;
    end
    if (rst_o !== v) chk(tag, rst_o, v);
  endtask
  initial begin
    repeat (3) cyc();
    chk("reset_rst", rst_o, 0);
    chk("reset_state", st_o, 0);
    rst_n = 1'b1;
    wait_st(4, 100, "to_run1");
    chk("stable_len1", last_stab, 8);
    chk("stagger01", rise[1] - rise[0], 5);
    chk("stagger02", rise[2] - rise[0], 10);
    chk("run_with_last", cyc_n, rise[2]);
    pb = 1'b0;
    repeat (3) cyc();
    pb = 1'b1;
    repeat (10) cyc();
    chk("glitch_rst", rst_o, 7);
    chk("glitch_state", st_o, 4);
    pb = 1'b0;
    t0 = cyc_n;
    wait_st(0, 20, "press");
    chk("press_latency", cyc_n - t0, 7);
    chk("press_rst", rst_o, 0);
    pb = 1'b1;
    wait_st(4, 100, "to_run2");
    chk("stagger12", rise[2] - rise[1], 5);
    pb = 1'b0;
    wait_st(0, 20, "hold3");
    pb = 1'b1;
    wait_st(2, 40, "stable3");
    repeat (4) cyc();
    lk = 1'b0;
    cyc();
    lk = 1'b1;
    cyc();
    cyc();
    chk("flicker_state", st_o, 1);
    wait_st(4, 100, "to_run3");
    chk("stable_len3", last_stab, 8);
    chk("flicker_count", llc, 0);
    lk = 1'b0;
    t0 = cyc_n;
    wait_st(1, 10, "loss");
    chk("loss_latency", cyc_n - t0, 3);
    chk("loss_count", llc, 1);
    chk("loss_rst", rst_o, 0);
    lk = 1'b1;
    for (int i = 0; i < 299; i++) begin
      wait_st(4, 100, "rerun");
      lk = 1'b0;
      wait_st(1, 10, "reloss");
      lk = 1'b1;
    end
    chk("saturated", llc, 255);
    wait_st(4, 100, "run6");
    lk = 1'b0;
    wait_st(1, 10, "loss6");
    lk = 1'b1;
    wait_rst(3, 100, "rel011");
    rst_n = 1'b0;
    cyc();
    chk("midrel_rst", rst_o, 0);
    chk("midrel_state", st_o, 0);
    chk("midrel_count", llc, 0);
    chk("midrel_all", all_rel, 0);
    rst_n = 1'b1;
    wait_st(3, 100, "rel5");
    pb = 1'b0;
    cyc();
    chk("rel001", rst_o, 1);
    repeat (3) cyc();
    lk = 1'b0;
    repeat (3) cyc();
    chk("both_state", st_o, 0);
    chk("both_rst", rst_o, 0);
    chk("both_count", llc, 1);
    pb = 1'b1;
    lk = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) pb = ~pb;
      if ($urandom_range(59) == 0) lk = ~lk;
      rst_n = $urandom_range(499) != 0;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
